decode_stage: RTL and testbench

//  Consumer of the fetch stage's 145-bit D bundle. Registers D (stall/bubble), splits fields,

---
 rtl/decode_stage_pkg.sv | 102 ++++++++++
 rtl/decode_stage_regfile.sv | 32 +++
 rtl/decode_stage.sv | 146 ++++++++++++++
 tb/tb_decode_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared Y86-64 definitions for the decode stage: icode/stat codes, register ids,
// the fetch-to-decode and decode-to-execute bundle layouts, and the forwarding selector.
package decode_stage_pkg;

  localparam int DATA_W = 64;
  localparam int NREG   = 15;
  localparam int D_W    = 145;

  localparam logic [3:0] RNONE  = 4'hF;
  localparam logic [3:0] RSP_ID = 4'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  // Field order matches the fetch bundle bit layout, MSB first.
  typedef struct packed {
    logic              imem_err;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [DATA_W-1:0] valc;
    logic [DATA_W-1:0] valp;
  } d_bundle_t;

  typedef struct packed {
    logic [2:0]        stat;
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [DATA_W-1:0] valc;
    logic [DATA_W-1:0] vala;
    logic [DATA_W-1:0] valb;
    logic [3:0]        dste;
    logic [3:0]        dstm;
    logic [3:0]        srca;
    logic [3:0]        srcb;
  } e_bundle_t;

  function automatic d_bundle_t d_nop();
    d_bundle_t b;
    b.imem_err = 1'b0;
    b.icode    = I_NOP;
    b.ifun     = 4'h0;
    b.ra       = RNONE;
    b.rb       = RNONE;
    b.valc     = '0;
    b.valp     = '0;
    return b;
  endfunction

  function automatic e_bundle_t e_nop();
    e_bundle_t b;
    b.stat  = STAT_AOK;
    b.icode = I_NOP;
    b.ifun  = 4'h0;
    b.valc  = '0;
    b.vala  = '0;
    b.valb  = '0;
    b.dste  = RNONE;
    b.dstm  = RNONE;
    b.srca  = RNONE;
    b.srcb  = RNONE;
    return b;
  endfunction

  // Youngest producer wins: e_dstE > M_dstM > M_dstE > W_dstM > W_dstE > regfile.
  function automatic logic [DATA_W-1:0] fwd_val(
    input logic [3:0]        src,
    input logic [DATA_W-1:0] rf_val,
    input logic [3:0]        e_dste, input logic [DATA_W-1:0] e_vale,
    input logic [3:0]        m_dstm, input logic [DATA_W-1:0] m_valm,
    input logic [3:0]        m_dste, input logic [DATA_W-1:0] m_vale,
    input logic [3:0]        w_dstm, input logic [DATA_W-1:0] w_valm,
    input logic [3:0]        w_dste, input logic [DATA_W-1:0] w_vale
  );
    logic [DATA_W-1:0] v;
    v = rf_val;
    if (src == RNONE)       v = '0;
    else if (src == e_dste) v = e_vale;
    else if (src == m_dstm) v = m_valm;
    else if (src == m_dste) v = m_vale;
    else if (src == w_dstm) v = w_valm;
    else if (src == w_dste) v = w_vale;
    return v;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 15x64 architectural register file: two combinational reads, two synchronous writes
// (M port written after E port so it wins on a shared id), asynchronous clear.
module decode_stage_regfile
  import decode_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [3:0]        src_a_i,
  input  logic [3:0]        src_b_i,
  output logic [DATA_W-1:0] val_a_o,
  output logic [DATA_W-1:0] val_b_o,
  input  logic [3:0]        dst_e_i,
  input  logic [DATA_W-1:0] val_e_i,
  input  logic [3:0]        dst_m_i,
  input  logic [DATA_W-1:0] val_m_i
);

  logic [DATA_W-1:0] rf_q [NREG];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      if (dst_e_i != RNONE) rf_q[dst_e_i] <= val_e_i;
      if (dst_m_i != RNONE) rf_q[dst_m_i] <= val_m_i;
    end
  end

  assign val_a_o = (src_a_i == RNONE) ? '0 : rf_q[src_a_i];
  assign val_b_o = (src_b_i == RNONE) ? '0 : rf_q[src_b_i];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register, register selection, regfile read with
// e/M/W forwarding, and the E pipeline register feeding execute.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [D_W-1:0]    D,
  input  logic              D_stall,
  input  logic              D_bubble,
  input  logic              E_bubble,
  input  logic [3:0]        e_dstE,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  input  logic [3:0]        W_dstE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  output logic [3:0]        d_srcA,
  output logic [3:0]        d_srcB,
  output logic [2:0]        E_stat,
  output logic [3:0]        E_icode,
  output logic [3:0]        E_ifun,
  output logic [DATA_W-1:0] E_valC,
  output logic [DATA_W-1:0] E_valA,
  output logic [DATA_W-1:0] E_valB,
  output logic [3:0]        E_dstE,
  output logic [3:0]        E_dstM,
  output logic [3:0]        E_srcA,
  output logic [3:0]        E_srcB
);

  d_bundle_t         d_q, d_d;
  e_bundle_t         e_q, e_d;
  logic [3:0]        src_a, src_b, dst_e, dst_m;
  logic [DATA_W-1:0] rf_a, rf_b, val_a, val_b;
  logic [2:0]        stat;

  // Stall has priority over bubble so a held instruction is never lost.
  always_comb begin
    d_d = d_q;
    if (D_stall)       d_d = d_q;
    else if (D_bubble) d_d = d_nop();
    else               d_d = d_bundle_t'(D);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) d_q <= d_nop();
    else       d_q <= d_d;
  end

  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (d_q.icode)
      I_CMOVXX, I_RMMOVQ, I_OPQ, I_PUSHQ: src_a = d_q.ra;
      I_RET, I_POPQ:                      src_a = RSP_ID;
      default:                            src_a = RNONE;
    endcase
    case (d_q.icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:         src_b = d_q.rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:    src_b = RSP_ID;
      default:                           src_b = RNONE;
    endcase
    case (d_q.icode)
      I_CMOVXX, I_IRMOVQ, I_OPQ:         dst_e = d_q.rb;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:    dst_e = RSP_ID;
      default:                           dst_e = RNONE;
    endcase
    case (d_q.icode)
      I_MRMOVQ, I_POPQ:                  dst_m = d_q.ra;
      default:                           dst_m = RNONE;
    endcase
  end

  decode_stage_regfile u_regfile (
    .clk_i   (clk),
    .reset_i (reset),
    .src_a_i (src_a),
    .src_b_i (src_b),
    .val_a_o (rf_a),
    .val_b_o (rf_b),
    .dst_e_i (W_dstE),
    .val_e_i (W_valE),
    .dst_m_i (W_dstM),
    .val_m_i (W_valM)
  );

  // Jumps and calls carry the return/fall-through address in valA instead of a register.
  always_comb begin
    if (d_q.icode == I_JXX || d_q.icode == I_CALL)
      val_a = d_q.valp;
    else
      val_a = fwd_val(src_a, rf_a, e_dstE, e_valE, M_dstM, m_valM,
                      M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
    val_b = fwd_val(src_b, rf_b, e_dstE, e_valE, M_dstM, m_valM,
                    M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
  end

  always_comb begin
    stat = STAT_AOK;
    if (d_q.imem_err)           stat = STAT_ADR;
    else if (d_q.icode > I_POPQ) stat = STAT_INS;
    else if (d_q.icode == I_HALT) stat = STAT_HLT;
  end

  always_comb begin
    e_d = e_nop();
    if (!E_bubble) begin
      e_d.stat  = stat;
      e_d.icode = d_q.icode;
      e_d.ifun  = d_q.ifun;
      e_d.valc  = d_q.valc;
      e_d.vala  = val_a;
      e_d.valb  = val_b;
      e_d.dste  = dst_e;
      e_d.dstm  = dst_m;
      e_d.srca  = src_a;
      e_d.srcb  = src_b;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) e_q <= e_nop();
    else       e_q <= e_d;
  end

  assign d_srcA  = src_a;
  assign d_srcB  = src_b;
  assign E_stat  = e_q.stat;
  assign E_icode = e_q.icode;
  assign E_ifun  = e_q.ifun;
  assign E_valC  = e_q.valc;
  assign E_valA  = e_q.vala;
  assign E_valB  = e_q.valb;
  assign E_dstE  = e_q.dste;
  assign E_dstM  = e_q.dstm;
  assign E_srcA  = e_q.srca;
  assign E_srcB  = e_q.srcb;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: register selection, forwarding priority, stall/bubble,
// regfile write ordering, status codes and asynchronous reset.
module tb_decode_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic [144:0] D;
  logic         D_stall, D_bubble, E_bubble;
  logic [3:0]   e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0]  e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]   d_srcA, d_srcB;
  logic [2:0]   E_stat;
  logic [3:0]   E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0]  E_valC, E_valA, E_valB;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .clk(clk), .reset(reset), .D(D), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .e_dstE(e_dstE), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .W_dstE(W_dstE), .W_dstM(W_dstM), .e_valE(e_valE), .M_valE(M_valE),
    .m_valM(m_valM), .W_valE(W_valE), .W_valM(W_valM), .d_srcA(d_srcA),
    .d_srcB(d_srcB), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE),
    .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [144:0] make_d(input logic err, input logic [3:0] icode,
      input logic [3:0] ifun, input logic [3:0] ra, input logic [3:0] rb,
      input logic [63:0] valc, input logic [63:0] valp);
    return {err, icode, ifun, ra, rb, valc, valp};
  endfunction

  // driver tasks
  task automatic set_idle();
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = '0;   M_valE = '0;   m_valM = '0;   W_valE = '0;   W_valM = '0;
  endtask

  task automatic write_reg(input logic [3:0] id, input logic [63:0] val);
    W_dstE = id; W_valE = val;
    tick();
    set_idle();
  endtask

  task automatic test_reset();
    reset = 1'b1; D_stall = 0; D_bubble = 0; E_bubble = 0;
    D = make_d(0, 4'h1, 0, 4'hF, 4'hF, 0, 0);
    set_idle();
    tick(); tick();
    checks++; if (E_icode !== 4'h1) begin errors++; $display("FAIL rst_icode got %0h exp 1", E_icode); end
    checks++; if (E_stat !== 3'd1) begin errors++; $display("FAIL rst_stat got %0d exp 1", E_stat); end
    checks++; if (E_dstE !== 4'hF) begin errors++; $display("FAIL rst_dstE got %0h exp f", E_dstE); end
    checks++; if (E_valA !== 64'd0) begin errors++; $display("FAIL rst_valA got %0h exp 0", E_valA); end
    checks++; if (d_srcA !== 4'hF) begin errors++; $display("FAIL rst_d_srcA got %0h exp f", d_srcA); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_opq();
    write_reg(4'd2, 64'd5);
    write_reg(4'd3, 64'd7);
    D = make_d(0, 4'h6, 4'h0, 4'd2, 4'd3, 0, 64'h2);
    tick();
    checks++; if (d_srcA !== 4'd2) begin errors++; $display("FAIL opq_d_srcA got %0h exp 2", d_srcA); end
    checks++; if (d_srcB !== 4'd3) begin errors++; $display("FAIL opq_d_srcB got %0h exp 3", d_srcB); end
    checks++; if (E_icode !== 4'h1) begin errors++; $display("FAIL opq_latency got %0h exp 1", E_icode); end
    tick();
    checks++; if (E_valA !== 64'd5) begin errors++; $display("FAIL opq_valA got %0h exp 5", E_valA); end
    checks++; if (E_valB !== 64'd7) begin errors++; $display("FAIL opq_valB got %0h exp 7", E_valB); end
    checks++; if (E_dstE !== 4'd3) begin errors++; $display("FAIL opq_dstE got %0h exp 3", E_dstE); end
    checks++; if (E_dstM !== 4'hF) begin errors++; $display("FAIL opq_dstM got %0h exp f", E_dstM); end
    checks++; if (E_icode !== 4'h6) begin errors++; $display("FAIL opq_icode got %0h exp 6", E_icode); end
  endtask

  task automatic test_forward();
    // D still holds addq %rdx,%rbx
    e_dstE = 4'd2; e_valE = 64'd99; W_dstE = 4'd2; W_valE = 64'd11;
    tick();
    checks++; if (E_valA !== 64'd99) begin errors++; $display("FAIL fwd_e_prio got %0d exp 99", E_valA); end
    set_idle();
    M_dstM = 4'd2; m_valM = 64'd42; M_dstE = 4'd2; M_valE = 64'd43;
    W_dstM = 4'd3; W_valM = 64'd8;  W_dstE = 4'd3; W_valE = 64'd9;
    tick();
    checks++; if (E_valA !== 64'd42) begin errors++; $display("FAIL fwd_mm_prio got %0d exp 42", E_valA); end
    checks++; if (E_valB !== 64'd8) begin errors++; $display("FAIL fwd_wm_prio got %0d exp 8", E_valB); end
    set_idle();
    tick();
    checks++; if (E_valA !== 64'd11) begin errors++; $display("FAIL rf_r2_after_w got %0d exp 11", E_valA); end
    checks++; if (E_valB !== 64'd8) begin errors++; $display("FAIL rf_same_id_m_wins got %0d exp 8", E_valB); end
    M_dstE = 4'd2; M_valE = 64'd43; W_dstM = 4'd2; W_valM = 64'd44;
    tick();
    checks++; if (E_valA !== 64'd43) begin errors++; $display("FAIL fwd_me_prio got %0d exp 43", E_valA); end
    set_idle();
  endtask

  task automatic test_call_jxx();
    D = make_d(0, 4'h8, 0, 4'hF, 4'hF, 64'h100, 64'h109);
    tick(); tick();
    checks++; if (E_valA !== 64'h109) begin errors++; $display("FAIL call_valA got %0h exp 109", E_valA); end
    checks++; if (E_srcB !== 4'd4) begin errors++; $display("FAIL call_srcB got %0h exp 4", E_srcB); end
    checks++; if (E_dstE !== 4'd4) begin errors++; $display("FAIL call_dstE got %0h exp 4", E_dstE); end
    checks++; if (E_valC !== 64'h100) begin errors++; $display("FAIL call_valC got %0h exp 100", E_valC); end
    checks++; if (E_srcA !== 4'hF) begin errors++; $display("FAIL call_srcA got %0h exp f", E_srcA); end
    D = make_d(0, 4'h7, 4'h3, 4'hF, 4'hF, 64'h200, 64'h209);
    tick(); tick();
    checks++; if (E_valA !== 64'h209) begin errors++; $display("FAIL jxx_valA got %0h exp 209", E_valA); end
    checks++; if (E_dstE !== 4'hF) begin errors++; $display("FAIL jxx_dstE got %0h exp f", E_dstE); end
    checks++; if (E_ifun !== 4'h3) begin errors++; $display("FAIL jxx_ifun got %0h exp 3", E_ifun); end
  endtask

  task automatic test_pop();
    write_reg(4'd4, 64'h1000);
    D = make_d(0, 4'hB, 0, 4'd3, 4'hF, 0, 64'h2);
    tick(); tick();
    checks++; if (E_srcA !== 4'd4) begin errors++; $display("FAIL pop_srcA got %0h exp 4", E_srcA); end
    checks++; if (E_srcB !== 4'd4) begin errors++; $display("FAIL pop_srcB got %0h exp 4", E_srcB); end
    checks++; if (E_dstE !== 4'd4) begin errors++; $display("FAIL pop_dstE got %0h exp 4", E_dstE); end
    checks++; if (E_dstM !== 4'd3) begin errors++; $display("FAIL pop_dstM got %0h exp 3", E_dstM); end
    checks++; if (E_valA !== 64'h1000) begin errors++; $display("FAIL pop_valA got %0h exp 1000", E_valA); end
  endtask

  task automatic test_stall_bubble();
    D = make_d(0, 4'h3, 0, 4'hF, 4'd1, 64'h55, 64'ha);
    tick();
    D_stall = 1; D = make_d(0, 4'h6, 0, 4'd2, 4'd3, 0, 0);
    tick();
    checks++; if (E_icode !== 4'h3) begin errors++; $display("FAIL stall1_icode got %0h exp 3", E_icode); end
    D_bubble = 1; D = make_d(0, 4'h9, 0, 4'hF, 4'hF, 0, 0);
    tick();
    checks++; if (E_icode !== 4'h3) begin errors++; $display("FAIL stall_over_bubble got %0h exp 3", E_icode); end
    checks++; if (E_valC !== 64'h55) begin errors++; $display("FAIL stall_valC got %0h exp 55", E_valC); end
    checks++; if (E_dstE !== 4'd1) begin errors++; $display("FAIL stall_dstE got %0h exp 1", E_dstE); end
    D_stall = 0;
    tick();
    checks++; if (E_icode !== 4'h3) begin errors++; $display("FAIL bubble_lat_icode got %0h exp 3", E_icode); end
    D_bubble = 0;
    tick();
    checks++; if (E_icode !== 4'h1) begin errors++; $display("FAIL d_bubble_icode got %0h exp 1", E_icode); end
    checks++; if (E_dstE !== 4'hF) begin errors++; $display("FAIL d_bubble_dstE got %0h exp f", E_dstE); end
  endtask

  task automatic test_regfile_wm();
    W_dstE = 4'd5; W_valE = 64'd1; W_dstM = 4'd5; W_valM = 64'd2;
    tick();
    set_idle();
    D = make_d(0, 4'h6, 0, 4'd5, 4'd6, 0, 0);
    tick();
    W_dstE = 4'd6; W_valE = 64'h77;
    tick();
    checks++; if (E_valA !== 64'd2) begin errors++; $display("FAIL rf_r5_m_wins got %0d exp 2", E_valA); end
    checks++; if (E_valB !== 64'h77) begin errors++; $display("FAIL fwd_w_same_cycle got %0h exp 77", E_valB); end
    set_idle();
    tick();
    checks++; if (E_valB !== 64'h77) begin errors++; $display("FAIL rf_r6_written got %0h exp 77", E_valB); end
  endtask

  task automatic test_e_bubble();
    E_bubble = 1;
    tick();
    checks++; if (E_icode !== 4'h1) begin errors++; $display("FAIL e_bubble_icode got %0h exp 1", E_icode); end
    checks++; if (E_valA !== 64'd0) begin errors++; $display("FAIL e_bubble_valA got %0h exp 0", E_valA); end
    checks++; if (E_srcA !== 4'hF) begin errors++; $display("FAIL e_bubble_srcA got %0h exp f", E_srcA); end
    E_bubble = 0;
  endtask

  task automatic test_stat();
    logic       err_t  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] code_t [4] = '{4'h1, 4'hC, 4'h0, 4'hC};
    logic [2:0] exp_t  [4] = '{3'd3, 3'd4, 3'd2, 3'd3};
    for (int i = 0; i < 4; i++) begin
      D = make_d(err_t[i], code_t[i], 0, 4'hF, 4'hF, 0, 0);
      tick(); tick();
      checks++;
      if (E_stat !== exp_t[i]) begin
        errors++; $display("FAIL stat_%0d got %0d exp %0d", i, E_stat, exp_t[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    D = make_d(0, 4'h6, 0, 4'd5, 4'd6, 0, 0);
    tick(); tick();
    #3 reset = 1'b1;
    #1;
    checks++; if (E_icode !== 4'h1) begin errors++; $display("FAIL midrst_icode got %0h exp 1", E_icode); end
    checks++; if (E_dstE !== 4'hF) begin errors++; $display("FAIL midrst_dstE got %0h exp f", E_dstE); end
    checks++; if (E_valA !== 64'd0) begin errors++; $display("FAIL midrst_valA got %0h exp 0", E_valA); end
    tick();
    reset = 1'b0;
    tick(); tick();
    checks++; if (E_valA !== 64'd0) begin errors++; $display("FAIL midrst_rf_r5 got %0h exp 0", E_valA); end
    checks++; if (E_valB !== 64'd0) begin errors++; $display("FAIL midrst_rf_r6 got %0h exp 0", E_valB); end
    checks++; if (E_icode !== 4'h6) begin errors++; $display("FAIL midrst_resume got %0h exp 6", E_icode); end
  endtask

  initial begin
    test_reset();
    test_opq();
    test_forward();
    test_call_jxx();
    test_pop();
    test_stall_bubble();
    test_regfile_wm();
    test_e_bubble();
    test_stat();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
